// File: rtl/floo_clint_if.sv
// rtl/floo_clint_if.sv - register request/response port of the core-local interruptor
interface floo_clint_if #(
    parameter int unsigned AddrWidth = 16
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_write_i;
    logic [31:0]          req_wdata_i;
    logic [3:0]           req_strb_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [31:0]          rsp_rdata_o;
    logic                 rsp_error_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/floo_clint.sv
// rtl/floo_clint.sv - core-local interruptor: msip bits, prescaled 64-bit mtime, mtimecmp/mtip
// Timer section (mtime, prescaler, mtimecmp, mtip) is built only with FLOO_CLINT_MTIP_EN defined.
module floo_clint #(
    parameter int unsigned NumCores   = 9,
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned RtcDivider = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    floo_clint_if.slave         bus,
    output logic [NumCores-1:0] msip_o,
    output logic [NumCores-1:0] mtip_o
);

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_accept;
    logic                 w_wr_en;
    logic [AddrWidth-1:0] w_addr;
    logic                 w_dec_err;
    logic [31:0]          w_rdata;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_error;
    logic [NumCores-1:0]  r_msip;
    logic [NumCores-1:0]  w_msip_next;

    assign w_accept = bus.req_valid_i & bus.req_ready_o;
    assign w_wr_en  = w_accept & bus.req_write_i;
    assign w_addr   = bus.req_addr_i & ~AddrWidth'(3);

`ifdef FLOO_CLINT_MTIP_EN
    localparam int unsigned PreW = (RtcDivider > 1) ? $clog2(RtcDivider) : 1;

    logic [PreW-1:0] r_presc;
    logic            w_tick;
    logic [63:0]     r_mtime;
    logic [63:0]     w_mtime_inc;
    logic [63:0]     w_mtime_next;
    logic [63:0]     r_mtimecmp [NumCores];
    logic [63:0]     w_cmp_next [NumCores];
    logic [NumCores-1:0] r_mtip;

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    assign w_tick      = (r_presc == PreW'(RtcDivider - 1));
    assign w_mtime_inc = w_tick ? r_mtime + 64'd1 : r_mtime;
`endif

    // Address decode, read mux and write merge for every register in one pass
    always_comb begin
        w_dec_err   = 1'b1;
        w_rdata     = '0;
        w_msip_next = r_msip;
        for (int i = 0; i < NumCores; i++) begin
            if (w_addr == AddrWidth'(4 * i)) begin
                w_dec_err = 1'b0;
                w_rdata   = {31'b0, r_msip[i]};
                if (w_wr_en && bus.req_strb_i[0]) w_msip_next[i] = bus.req_wdata_i[0];
            end
        end
`ifdef FLOO_CLINT_MTIP_EN
        w_mtime_next = w_mtime_inc;
        w_cmp_next   = r_mtimecmp;
        for (int i = 0; i < NumCores; i++) begin
            if (w_addr == AddrWidth'(32'h4000 + 8 * i)) begin
                w_dec_err = 1'b0;
                w_rdata   = r_mtimecmp[i][31:0];
                if (w_wr_en)
                    w_cmp_next[i][31:0] = merge32(r_mtimecmp[i][31:0], bus.req_wdata_i, bus.req_strb_i);
            end else if (w_addr == AddrWidth'(32'h4004 + 8 * i)) begin
                w_dec_err = 1'b0;
                w_rdata   = r_mtimecmp[i][63:32];
                if (w_wr_en)
                    w_cmp_next[i][63:32] = merge32(r_mtimecmp[i][63:32], bus.req_wdata_i, bus.req_strb_i);
            end
        end
        // Unwritten mtime bytes keep the incremented value so a concurrent tick is not lost
        if (w_addr == AddrWidth'(32'hBFF8)) begin
            w_dec_err = 1'b0;
            w_rdata   = r_mtime[31:0];
            if (w_wr_en) w_mtime_next[31:0] = merge32(w_mtime_inc[31:0], bus.req_wdata_i, bus.req_strb_i);
        end else if (w_addr == AddrWidth'(32'hBFFC)) begin
            w_dec_err = 1'b0;
            w_rdata   = r_mtime[63:32];
            if (w_wr_en) w_mtime_next[63:32] = merge32(w_mtime_inc[63:32], bus.req_wdata_i, bus.req_strb_i);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RESP;
            ST_RESP: begin
                if (w_accept)             w_state_next = ST_RESP;
                else if (bus.rsp_ready_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.rsp_valid_o = (r_state == ST_RESP);
        bus.req_ready_o = (r_state != ST_RESP) | bus.rsp_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_msip      <= '0;
        end else begin
            r_msip <= w_msip_next;
            if (w_accept) begin
                r_rsp_rdata <= bus.req_write_i ? 32'd0 : w_rdata;
                r_rsp_error <= w_dec_err;
            end
        end
    end

    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_error_o = r_rsp_error;
    assign msip_o          = r_msip;

`ifdef FLOO_CLINT_MTIP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= '0;
            r_mtime <= '0;
            r_mtip  <= '0;
            for (int i = 0; i < NumCores; i++) r_mtimecmp[i] <= '1;
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_cmp_next;
            for (int i = 0; i < NumCores; i++) r_mtip[i] <= (r_mtime >= r_mtimecmp[i]);
        end
    end

    assign mtip_o = r_mtip;
`else
    assign mtip_o = '0;
`endif

endmodule
